camera_capture: RTL and testbench



---
 rtl/camera_capture_if.sv | 22 ++
 rtl/camera_capture.sv | 189 ++++++++++++++++++
 tb/tb_camera_capture.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_capture_if.sv
// Bundles the camera byte bus and the pixel-FIFO write port of camera_capture.
// master = capture block, slave = camera/FIFO side (or a testbench standing in for them).
interface camera_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        full_fifo;
  logic        wr_en;
  logic [15:0] dout;
  logic        frame_done;
  logic        overflow;

  modport master (
    input  cam_vsync, cam_href, cam_data, full_fifo,
    output wr_en, dout, frame_done, overflow
  );

  modport slave (
    output cam_vsync, cam_href, cam_data, full_fifo,
    input  wr_en, dout, frame_done, overflow
  );
endinterface

// File: rtl/camera_capture.sv
// Camera-side pixel FIFO writer: samples VSYNC/HREF/DATA, packs byte pairs into RGB565,
// discards the first SKIP_FRAMES frames after reset and crops to H_ACTIVE x V_ACTIVE.
module camera_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  camera_capture_if.master bus
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  localparam int          SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    ST_SKIP     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } state_e;

  localparam state_e ST_RESET = (SKIP_FRAMES == 0) ? ST_WAIT_SOF : ST_SKIP;

  state_e              state_q, state_d;
  logic                vsync_s1_q, vsync_s1_d;
  logic                href_s1_q, href_s1_d;
  logic [7:0]          data_s1_q, data_s1_d;
  logic                vsync_prev_q, vsync_prev_d;
  logic                href_prev_q, href_prev_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic                byte_phase_q, byte_phase_d;
  logic [7:0]          hi_byte_q, hi_byte_d;
  logic [10:0]         pixel_x_q, pixel_x_d;
  logic [10:0]         line_y_q, line_y_d;
  logic                wr_en_q, wr_en_d;
  logic [15:0]         dout_q, dout_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;

  logic                sof_s;
  logic                eof_s;
  logic                href_fall_s;
  logic                eligible_s;
  logic [15:0]         pix_s;

  assign sof_s       = vsync_prev_q & ~vsync_s1_q;
  assign eof_s       = ~vsync_prev_q & vsync_s1_q;
  assign href_fall_s = href_prev_q & ~href_s1_q;
  assign eligible_s  = (pixel_x_q < H_LIM) && (line_y_q < V_LIM);
  assign pix_s       = {hi_byte_q, data_s1_q};

  assign bus.wr_en      = wr_en_q;
  assign bus.dout       = dout_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

  // State and pipeline registers; vsync history resets high so a blanking bus gives no sof.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      vsync_s1_q   <= 1'b1;
      href_s1_q    <= 1'b0;
      data_s1_q    <= 8'h00;
      vsync_prev_q <= 1'b1;
      href_prev_q  <= 1'b0;
      skip_cnt_q   <= '0;
      byte_phase_q <= 1'b0;
      hi_byte_q    <= 8'h00;
      pixel_x_q    <= 11'd0;
      line_y_q     <= 11'd0;
      wr_en_q      <= 1'b0;
      dout_q       <= 16'h0000;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_s1_q   <= vsync_s1_d;
      href_s1_q    <= href_s1_d;
      data_s1_q    <= data_s1_d;
      vsync_prev_q <= vsync_prev_d;
      href_prev_q  <= href_prev_d;
      skip_cnt_q   <= skip_cnt_d;
      byte_phase_q <= byte_phase_d;
      hi_byte_q    <= hi_byte_d;
      pixel_x_q    <= pixel_x_d;
      line_y_q     <= line_y_d;
      wr_en_q      <= wr_en_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state, pixel packing and write decisions.
  always_comb begin
    vsync_s1_d   = bus.cam_vsync;
    href_s1_d    = bus.cam_href;
    data_s1_d    = bus.cam_data;
    vsync_prev_d = vsync_s1_q;
    href_prev_d  = href_s1_q;
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    byte_phase_d = byte_phase_q;
    hi_byte_d    = hi_byte_q;
    pixel_x_d    = pixel_x_q;
    line_y_d     = line_y_q;
    wr_en_d      = 1'b0;
    dout_d       = dout_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      ST_SKIP: begin
        // skip_cnt holds the number of frames already discarded.
        if (sof_s) begin
          if (skip_cnt_q == SKIP_LIM) begin
            state_d      = ST_CAPTURE;
            byte_phase_d = 1'b0;
            pixel_x_d    = 11'd0;
            line_y_d     = 11'd0;
          end else begin
            skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          end
        end else begin
          state_d = ST_SKIP;
        end
      end

      ST_WAIT_SOF: begin
        if (sof_s) begin
          state_d      = ST_CAPTURE;
          byte_phase_d = 1'b0;
          pixel_x_d    = 11'd0;
          line_y_d     = 11'd0;
        end else begin
          state_d = ST_WAIT_SOF;
        end
      end

      ST_CAPTURE: begin
        if (sof_s) begin
          byte_phase_d = 1'b0;
          pixel_x_d    = 11'd0;
          line_y_d     = 11'd0;
        end else if (eof_s) begin
          frame_done_d = 1'b1;
          state_d      = ST_WAIT_SOF;
        end else if (href_s1_q) begin
          byte_phase_d = ~byte_phase_q;
          if (!byte_phase_q) begin
            hi_byte_d = data_s1_q;
          end else begin
            // A dropped pixel still advances pixel_x so later pixels keep their column.
            if (pixel_x_q < H_LIM) begin
              pixel_x_d = pixel_x_q + 11'd1;
            end else begin
              pixel_x_d = pixel_x_q;
            end
            if (eligible_s && !bus.full_fifo) begin
              wr_en_d = 1'b1;
              dout_d  = pix_s;
            end else if (eligible_s) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_d = 1'b0;
            end
          end
        end else if (href_fall_s) begin
          byte_phase_d = 1'b0;
          pixel_x_d    = 11'd0;
          if (line_y_q < V_LIM) begin
            line_y_d = line_y_q + 11'd1;
          end else begin
            line_y_d = line_y_q;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_camera_capture.sv
// Self-checking bench for camera_capture: directed frames plus randomized lines, checked
// every cycle against a frame/line/byte-count reference model.
module tb_camera_capture;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int SKIP = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  camera_capture_if cif ();

  camera_capture #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .SKIP_FRAMES(SKIP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(cif)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int          wr_cnt;
  int          fd_cnt;
  logic [15:0] wr_log[$];
  logic        last_wr;

  logic [7:0]  line_buf[$];
  logic        full_buf[$];

  // Reference model: what the DUT sampled on the last two edges plus frame/line/byte counts.
  logic        m_seen_vs, m_seen_hr, m_before_vs, m_before_hr;
  logic [7:0]  m_seen_d;
  logic [7:0]  m_hi;
  int          m_frames;
  bit          m_cap;
  int          m_line, m_bidx;
  logic        exp_wr, exp_fd, exp_ovf;
  logic [15:0] exp_dout;

  logic [15:0] exp_dir[3]  = '{16'hF800, 16'h07E0, 16'h001F};
  logic [15:0] exp_odd[3]  = '{16'h1122, 16'h3344, 16'hAABB};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seen_vs   = 1'b1;
    m_seen_hr   = 1'b0;
    m_seen_d    = 8'h00;
    m_before_vs = 1'b1;
    m_before_hr = 1'b0;
    m_frames    = 0;
    m_cap       = 1'b0;
    m_line      = 0;
    m_bidx      = 0;
    m_hi        = 8'h00;
    exp_wr      = 1'b0;
    exp_fd      = 1'b0;
    exp_ovf     = 1'b0;
    exp_dout    = 16'h0000;
  endtask

  // Evaluates the byte the DUT sampled last edge, with full_fifo as it is now.
  task automatic model_step(input logic vs, input logic hr, input logic [7:0] d, input logic full);
    bit sof, eof, hfall;
    sof    = m_before_vs && !m_seen_vs;
    eof    = !m_before_vs && m_seen_vs;
    hfall  = m_before_hr && !m_seen_hr;
    exp_wr = 1'b0;
    exp_fd = 1'b0;
    if (sof) begin
      m_frames++;
      if (m_frames > SKIP) begin
        m_cap  = 1'b1;
        m_line = 0;
        m_bidx = 0;
      end
    end else if (eof) begin
      if (m_cap) begin
        exp_fd = 1'b1;
        m_cap  = 1'b0;
      end
    end else if (m_cap) begin
      if (m_seen_hr) begin
        if (m_bidx % 2 == 0) begin
          m_hi = m_seen_d;
        end else if ((m_bidx / 2) < H && m_line < V) begin
          if (full) begin
            exp_ovf = 1'b1;
          end else begin
            exp_wr   = 1'b1;
            exp_dout = {m_hi, m_seen_d};
          end
        end
        m_bidx++;
      end else if (hfall) begin
        m_line++;
        m_bidx = 0;
      end
    end
    m_before_vs = m_seen_vs;
    m_before_hr = m_seen_hr;
    m_seen_vs   = vs;
    m_seen_hr   = hr;
    m_seen_d    = d;
  endtask

  task automatic step(input logic vs, input logic hr, input logic [7:0] d,
                      input logic full, input logic r);
    @(negedge clk);
    if (chk_en) begin
      check("wr_en", {31'd0, cif.wr_en}, {31'd0, exp_wr});
      check("dout", {16'd0, cif.dout}, {16'd0, exp_dout});
      check("frame_done", {31'd0, cif.frame_done}, {31'd0, exp_fd});
      check("overflow", {31'd0, cif.overflow}, {31'd0, exp_ovf});
      check("no_back_to_back", {31'd0, cif.wr_en & last_wr}, 32'd0);
      if (cif.wr_en === 1'b1) begin
        wr_cnt++;
        wr_log.push_back(cif.dout);
      end
      if (cif.frame_done === 1'b1) fd_cnt++;
      last_wr = cif.wr_en;
    end
    cif.cam_vsync = vs;
    cif.cam_href  = hr;
    cif.cam_data  = d;
    cif.full_fifo = full;
    rst           = r;
    if (r) model_reset();
    else   model_step(vs, hr, d, full);
  endtask

  task automatic blank(input int n);
    repeat (n) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic start_frame();
    blank(3);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic end_frame();
    blank(4);
  endtask

  task automatic send_line(input int gap);
    foreach (line_buf[i]) step(1'b0, 1'b1, line_buf[i], full_buf[i], 1'b0);
    repeat (gap) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rand_line(input int nbytes, input bit rnd_full);
    line_buf.delete();
    full_buf.delete();
    for (int i = 0; i < nbytes; i++) begin
      line_buf.push_back(8'($urandom));
      full_buf.push_back(rnd_full ? ($urandom_range(0, 7) == 0) : 1'b0);
    end
  endtask

  task automatic begin_count();
    wr_cnt = 0;
    fd_cnt = 0;
    wr_log.delete();
  endtask

  task automatic three_frames(input string tag);
    for (int f = 0; f < 3; f++) begin
      begin_count();
      start_frame();
      for (int l = 0; l < 2; l++) begin
        rand_line(8, 1'b0);
        send_line(2);
      end
      end_frame();
      check({tag, "_writes"}, wr_cnt, (f == 2) ? 32'd8 : 32'd0);
      check({tag, "_frame_done"}, fd_cnt, (f == 2) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    last_wr       = 1'b0;
    cif.cam_vsync = 1'b1;
    cif.cam_href  = 1'b0;
    cif.cam_data  = 8'h00;
    cif.full_fifo = 1'b0;
    rst           = 1'b1;
    model_reset();
    begin_count();

    // Reset with the bus in vertical blanking.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_en = 1'b1;
    blank(1);
    check("reset_wr_en", {31'd0, cif.wr_en}, 32'd0);
    check("reset_dout", {16'd0, cif.dout}, 32'd0);
    check("reset_overflow", {31'd0, cif.overflow}, 32'd0);

    // Two skipped frames, then the first captured 4x2 frame.
    three_frames("skip");

    // RGB565 packing of primary colours.
    begin_count();
    start_frame();
    line_buf = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    full_buf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_line(3);
    end_frame();
    check("rgb_count", wr_cnt, 32'd3);
    for (int i = 0; i < 3; i++)
      check("rgb_dout", (i < wr_log.size()) ? {16'd0, wr_log[i]} : 32'hFFFF_FFFF, {16'd0, exp_dir[i]});

    // Cropping: 6-pixel lines, 3 lines.
    begin_count();
    start_frame();
    for (int l = 0; l < 3; l++) begin
      rand_line(12, 1'b0);
      send_line(2);
    end
    end_frame();
    check("crop_writes", wr_cnt, 32'd8);
    check("crop_frame_done", fd_cnt, 32'd1);

    // FIFO full while the second pixel completes.
    begin_count();
    start_frame();
    rand_line(8, 1'b0);
    full_buf[3] = 1'b1;
    full_buf[4] = 1'b1;
    send_line(3);
    end_frame();
    check("full_writes", wr_cnt, 32'd3);
    check("full_overflow", {31'd0, cif.overflow}, 32'd1);

    // Odd byte count: dangling byte dropped, next line starts fresh.
    begin_count();
    start_frame();
    line_buf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    full_buf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_line(2);
    line_buf = '{8'hAA, 8'hBB};
    full_buf = '{1'b0, 1'b0};
    send_line(3);
    end_frame();
    check("odd_count", wr_cnt, 32'd3);
    for (int i = 0; i < 3; i++)
      check("odd_dout", (i < wr_log.size()) ? {16'd0, wr_log[i]} : 32'hFFFF_FFFF, {16'd0, exp_odd[i]});
    check("overflow_sticky", {31'd0, cif.overflow}, 32'd1);

    // Randomized frames: line counts, odd lengths, short gaps and FIFO back-pressure.
    for (int f = 0; f < 6; f++) begin
      start_frame();
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        rand_line(int'($urandom_range(0, 11)), 1'b1);
        send_line(int'($urandom_range(1, 3)));
      end
      end_frame();
    end

    // Reset between the two bytes of a pixel, then frame skipping starts over.
    start_frame();
    step(1'b0, 1'b1, 8'hAB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hCD, 1'b0, 1'b1);
    begin_count();
    blank(3);
    check("midrst_writes", wr_cnt, 32'd0);
    check("midrst_overflow", {31'd0, cif.overflow}, 32'd0);
    check("midrst_dout", {16'd0, cif.dout}, 32'd0);
    three_frames("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
